// File: rtl/core_pkg.sv
// Shared encodings for the RV32I decode stage: immediate selects, ALU ops,
// write-back selects, opcodes and the ID/EX control bundle.
package core_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_U    = 3'd5
    } imm_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic        valid;
        alu_op_e     alu_op;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        branch;
        logic        jump;
        wb_sel_e     wb_sel;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        illegal;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ctrl_if.sv
// Front-end / execute-side signals of the decode controller, bundled so the
// core and the bench connect through one port.
interface id_ctrl_if;

    logic [31:0] instr_i;
    logic        instr_valid_i;
    logic        ex_stall_i;
    logic        flush_i;
    logic [2:0]  imm_sel_o;
    logic        stall_if_o;
    logic        ex_valid_o;
    logic [3:0]  ex_alu_op_o;
    logic        ex_alu_src_a_o;
    logic        ex_alu_src_b_o;
    logic        ex_mem_read_o;
    logic        ex_mem_write_o;
    logic        ex_reg_write_o;
    logic        ex_branch_o;
    logic        ex_jump_o;
    logic [1:0]  ex_wb_sel_o;
    logic [4:0]  ex_rd_o;
    logic [2:0]  ex_funct3_o;
    logic        ex_illegal_o;

    modport master (
        output instr_i, instr_valid_i, ex_stall_i, flush_i,
        input  imm_sel_o, stall_if_o, ex_valid_o, ex_alu_op_o, ex_alu_src_a_o,
               ex_alu_src_b_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o,
               ex_branch_o, ex_jump_o, ex_wb_sel_o, ex_rd_o, ex_funct3_o,
               ex_illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, ex_stall_i, flush_i,
        output imm_sel_o, stall_if_o, ex_valid_o, ex_alu_op_o, ex_alu_src_a_o,
               ex_alu_src_b_o, ex_mem_read_o, ex_mem_write_o, ex_reg_write_o,
               ex_branch_o, ex_jump_o, ex_wb_sel_o, ex_rd_o, ex_funct3_o,
               ex_illegal_o
    );

endinterface

// File: rtl/id_decode.sv
// Pure combinational RV32I opcode decoder: control bundle, immediate select,
// source-register usage and illegal-opcode flag.
module id_decode
    import core_pkg::*;
(
    input  logic [31:0] i_instr,
    output id_ex_ctrl_t o_ctrl,
    output imm_sel_e    o_imm_sel,
    output logic        o_use_rs1,
    output logic        o_use_rs2,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rd;
    logic       w_alt;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_rd     = i_instr[11:7];
    assign w_alt    = i_instr[30];

    // SUB only exists in the register form; the immediate form has no SUBI.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                                input logic alt,
                                                input logic is_reg);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        o_ctrl    = CTRL_BUBBLE;
        o_imm_sel = IMM_NONE;
        o_use_rs1 = 1'b1;
        o_use_rs2 = 1'b0;
        o_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                o_imm_sel        = IMM_U;
                o_ctrl.alu_op    = ALU_PASSB;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b0;
            end
            OPC_AUIPC: begin
                o_imm_sel        = IMM_U;
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b0;
            end
            OPC_JAL: begin
                o_imm_sel        = IMM_J;
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.wb_sel    = WB_PC4;
                o_ctrl.reg_write = 1'b1;
                o_use_rs1        = 1'b0;
            end
            OPC_JALR: begin
                o_imm_sel        = IMM_I;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.jump      = 1'b1;
                o_ctrl.wb_sel    = WB_PC4;
                o_ctrl.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                o_imm_sel     = IMM_B;
                o_ctrl.alu_op = ALU_SUB;
                o_ctrl.branch = 1'b1;
                o_use_rs2     = 1'b1;
            end
            OPC_LOAD: begin
                o_imm_sel        = IMM_I;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.wb_sel    = WB_MEM;
                o_ctrl.reg_write = 1'b1;
            end
            OPC_STORE: begin
                o_imm_sel        = IMM_S;
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_use_rs2        = 1'b1;
            end
            OPC_OP_IMM: begin
                o_imm_sel        = IMM_I;
                o_ctrl.alu_op    = alu_from_funct3(w_funct3, w_alt, 1'b0);
                o_ctrl.alu_src_b = 1'b1;
                o_ctrl.reg_write = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.alu_op    = alu_from_funct3(w_funct3, w_alt, 1'b1);
                o_ctrl.reg_write = 1'b1;
                o_use_rs2        = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                o_use_rs1 = 1'b0;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
        // x0 is hardwired, so a write to it is dropped at decode.
        if (!o_illegal) begin
            o_ctrl.valid  = 1'b1;
            o_ctrl.funct3 = w_funct3;
            if (w_rd == 5'd0) begin
                o_ctrl.reg_write = 1'b0;
            end
            o_ctrl.rd = o_ctrl.reg_write ? w_rd : 5'd0;
        end
    end

endmodule

// File: rtl/id_ctrl.sv
// Decode-stage controller: load-use hazard detection, flush/stall/bubble
// arbitration and the ID/EX control register.
module id_ctrl
    import core_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    id_ctrl_if.slave bus
);

    id_ex_ctrl_t w_dec_ctrl;
    id_ex_ctrl_t w_issue;
    imm_sel_e    w_imm_sel;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_illegal;
    logic        w_rs1_hit;
    logic        w_rs2_hit;
    logic        w_load_use;
    id_ex_ctrl_t r_ex;

    id_decode u_decode (
        .i_instr   (bus.instr_i),
        .o_ctrl    (w_dec_ctrl),
        .o_imm_sel (w_imm_sel),
        .o_use_rs1 (w_use_rs1),
        .o_use_rs2 (w_use_rs2),
        .o_illegal (w_illegal)
    );

    assign w_rs1_hit  = w_use_rs1 && (bus.instr_i[19:15] == r_ex.rd);
    assign w_rs2_hit  = w_use_rs2 && (bus.instr_i[24:20] == r_ex.rd);
    assign w_load_use = r_ex.valid && r_ex.mem_read && (r_ex.rd != 5'd0) &&
                        bus.instr_valid_i && (w_rs1_hit || w_rs2_hit);

    always_comb begin
        w_issue         = w_dec_ctrl;
        w_issue.valid   = w_dec_ctrl.valid && bus.instr_valid_i;
        w_issue.illegal = w_illegal && bus.instr_valid_i;
    end

    // Flush outranks the EX stall: the killed instruction must never be held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= CTRL_BUBBLE;
        end else if (bus.flush_i) begin
            r_ex <= CTRL_BUBBLE;
        end else if (bus.ex_stall_i) begin
            r_ex <= r_ex;
        end else if (w_load_use) begin
            r_ex <= CTRL_BUBBLE;
        end else begin
            r_ex <= w_issue;
        end
    end

    // Reset drops the front-end stall immediately, even while EX is stalled.
    assign bus.stall_if_o = rst_n && !bus.flush_i &&
                            (bus.ex_stall_i || w_load_use);
    assign bus.imm_sel_o  = bus.instr_valid_i ? w_imm_sel : IMM_NONE;

    assign bus.ex_valid_o     = r_ex.valid;
    assign bus.ex_alu_op_o    = r_ex.alu_op;
    assign bus.ex_alu_src_a_o = r_ex.alu_src_a;
    assign bus.ex_alu_src_b_o = r_ex.alu_src_b;
    assign bus.ex_mem_read_o  = r_ex.mem_read;
    assign bus.ex_mem_write_o = r_ex.mem_write;
    assign bus.ex_reg_write_o = r_ex.reg_write;
    assign bus.ex_branch_o    = r_ex.branch;
    assign bus.ex_jump_o      = r_ex.jump;
    assign bus.ex_wb_sel_o    = r_ex.wb_sel;
    assign bus.ex_rd_o        = r_ex.rd;
    assign bus.ex_funct3_o    = r_ex.funct3;
    assign bus.ex_illegal_o   = r_ex.illegal;

endmodule

// File: doc/id_ctrl.md
# id_ctrl

Instruction-decode stage controller for the pipelined RV32I core. It decodes the IF/ID instruction word and drives the immediate-generator select combinationally in the same cycle. It registers the remaining control bundle into the ID/EX pipeline register and detects load-use hazards against the instruction it holds in EX. It also arbitrates stall, flush and bubble injection between the front end and the execute stage.

## Interface
Parameters: none; all encodings come from `core_pkg`.

- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr_i`  in  32  instruction from the IF/ID register
- `instr_valid_i`  in  1  `instr_i` holds a real instruction
- `ex_stall_i`  in  1  downstream cannot accept; hold ID/EX contents
- `flush_i`  in  1  taken branch/jump resolved in EX; kill the ID instruction
- `imm_sel_o`  out  3  to Imm_Gen: 0 none, 1 I, 2 S, 3 B, 4 J, 5 U (combinational)
- `stall_if_o`  out  1  hold PC and IF/ID this cycle (combinational)
- `ex_valid_o`  out  1  ID/EX holds a live instruction
- `ex_alu_op_o`  out  4  `alu_op_e`
- `ex_alu_src_a_o`  out  1  0 rs1, 1 PC
- `ex_alu_src_b_o`  out  1  0 rs2, 1 immediate
- `ex_mem_read_o`, `ex_mem_write_o`, `ex_reg_write_o`, `ex_branch_o`, `ex_jump_o`  out  1 each
- `ex_wb_sel_o`  out  2  0 ALU, 1 memory, 2 PC+4
- `ex_rd_o`  out  5  destination register
- `ex_funct3_o`  out  3  instr[14:12], passed to branch and LSU
- `ex_illegal_o`  out  1  unrecognised opcode, with `ex_valid_o`=0

## Operation
- Decode by opcode (instr[6:0]):
  - LUI 0110111: U, PASSB, srcB=imm, reg_write
  - AUIPC 0010111: U, ADD, srcA=PC, srcB=imm, reg_write
  - JAL 1101111: J, ADD, srcA=PC, srcB=imm, jump, wb=2, reg_write
  - JALR 1100111: I, ADD, srcB=imm, jump, wb=2, reg_write
  - BRANCH 1100011: B, SUB, branch, no writes
  - LOAD 0000011: I, ADD, srcB=imm, mem_read, wb=1, reg_write
  - STORE 0100011: S, ADD, srcB=imm, mem_write
  - OP-IMM 0010011: I, op from funct3; funct3=101 takes instr[30] (SRA/SRL); funct3=000 always ADD
  - OP 0110011: imm_sel 0, srcB=rs2, op from funct3 and instr[30] (SUB, SRA)
  - FENCE 0001111 and SYSTEM 1110011: valid NOP (no writes, imm_sel 0)
  - anything else: imm_sel 0, bubble, `ex_illegal_o`=1
- `imm_sel_o` is 0 whenever `instr_valid_i`=0.
- `reg_write` is forced to 0 when rd=x0.
- Register-use rules:
  - rs1 is used by every opcode except LUI, AUIPC, JAL, FENCE, SYSTEM.
  - rs2 is used by OP, STORE, BRANCH.
- Load-use hazard: `ex_valid_o` & `ex_mem_read_o` & `ex_rd_o`≠0 & (used rs1==`ex_rd_o` or used rs2==`ex_rd_o`) & `instr_valid_i`.
- ID/EX update priority, evaluated each cycle:
  1. flush: load a bubble; `stall_if_o`=0.
  2. `ex_stall_i`: hold all `ex_*`; `stall_if_o`=1.
  3. load-use: load a bubble; `stall_if_o`=1.
  4. Otherwise: load the decoded bundle; `ex_valid_o`=`instr_valid_i` & legal.
- A bubble sets every `ex_*` to 0.

## Timing
- `imm_sel_o` and `stall_if_o`: zero latency, combinational from `instr_i` and the ID/EX state.
- `ex_*`: one-cycle latency, registered on the rising edge of `clk`.
- Load-use stall lasts exactly one cycle. The load leaves EX and the hazard clears, provided `ex_stall_i`=0.
- Reset: `rst_n` low clears all `ex_*` to 0 immediately, without waiting for a clock edge. With the registers cleared, `stall_if_o`=0 and `imm_sel_o` follows `instr_i`.
- Reset asserted mid-stall drops the stall in the same cycle.
- Simultaneous flush and `ex_stall_i`: flush wins and EX receives a bubble.
- Simultaneous flush and load-use: bubble, `stall_if_o`=0.

## Structure
- `core_pkg` holds:
  - `imm_sel_e` (values 0–5 as listed)
  - `alu_op_e`: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10
  - `wb_sel_e`
  - opcode localparams
  - `id_ex_ctrl_t`, a packed struct of the `ex_*` bundle
- One sub-module, `id_decode`: purely combinational, mapping `instr_i` to `id_ex_ctrl_t`, `imm_sel`, the use_rs1/use_rs2 flags and the illegal flag.
- `id_ctrl` contains the hazard logic, the priority mux and the ID/EX register.

## Test plan
- `instr_i`=0x00500093 (addi x1,x0,5) -> `imm_sel_o`=1 in the same cycle. Next cycle: `ex_alu_op_o`=ADD, `ex_alu_src_b_o`=1, `ex_reg_write_o`=1, `ex_rd_o`=1.
- Sweep one instruction per opcode: lui x2 (U=5), sw (S=2), beq (B=3), jal x1 (J=4), add (0) -> `imm_sel_o` and registered bundle match the decode rules above. `add x0,...` gives `ex_reg_write_o`=0.
- lw x5,0(x1) then add x6,x5,x7 -> `stall_if_o`=1 for exactly one cycle, EX gets one bubble, then the add issues. Repeat with add x6,x7,x8: no stall.
- Assert `flush_i` and `ex_stall_i` together while a valid instruction is in ID -> next cycle `ex_valid_o`=0 and `stall_if_o`=0 during the flush cycle.
- `ex_stall_i` held for 3 cycles -> `ex_*` unchanged across all 3 cycles and `stall_if_o`=1 throughout.
- Opcode 0x7F: `ex_illegal_o`=1 and `ex_valid_o`=0.
- Drop `rst_n` mid-stall -> all `ex_*`=0 and `stall_if_o`=0 without waiting for a clock edge.
